// File: rtl/system_0_sysid_pkg.sv
// Shared types and constants for the sysid checker: FSM state encoding,
// sysid slave word addresses and the default expected identity words.
package system_0_sysid_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        CMP   = 2'd3
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd0;
    localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1671069002;

    function automatic logic word_match(input logic [31:0] observed,
                                        input logic [31:0] expected);
        return observed == expected;
    endfunction

endpackage

// File: rtl/system_0_sysid_period_timer.sv
// Free-running recheck down-counter; expire is high while the count is zero.
// Only built when SYSID_PERIODIC_CHECK_EN is defined.
`ifdef SYSID_PERIODIC_CHECK_EN
module system_0_sysid_period_timer
    import system_0_sysid_pkg::*;
#(
    parameter int unsigned RECHECK_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic reload,
    output logic expire
);

    localparam int unsigned CW = $clog2(RECHECK_CYCLES);
    localparam logic [CW-1:0] RELOAD_VAL = CW'(RECHECK_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= RELOAD_VAL;
        end else if (reload || count == '0) begin
            count <= RELOAD_VAL;
        end else begin
            count <= count - CW'(1);
        end
    end

    assign expire = (count == '0);

endmodule
`endif

// File: rtl/system_0_sysid_checker.sv
// Reads the sysid ID and timestamp words over Avalon-MM and compares them with
// the build-time values. SYSID_PERIODIC_CHECK_EN adds an automatic recheck timer.
module system_0_sysid_checker
    import system_0_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
    parameter int unsigned READ_LATENCY   = 0,
    parameter int unsigned RECHECK_CYCLES = 1000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        clear_sticky,
    output logic        sysid_address,
    output logic        sysid_read,
    input  logic [31:0] sysid_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        fail_sticky,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);

    if (READ_LATENCY > 3) begin : g_bad_latency
        $error("READ_LATENCY must be in 0..3");
    end
    if (RECHECK_CYCLES < 16) begin : g_bad_period
        $error("RECHECK_CYCLES must be at least 16");
    end

    localparam logic [1:0] LAT_MAX = 2'(READ_LATENCY);

    state_t      state;
    state_t      state_next;
    logic [1:0]  lat_cnt;
    logic        lat_last;
    logic [31:0] id_raw;
    logic [31:0] ts_raw;
    logic        id_match;
    logic        ts_match;
    logic        done_pending;
    logic        trigger;

`ifdef SYSID_PERIODIC_CHECK_EN
    logic period_expire;

    // Reload on the edge that raises done, so the next expiry lands a full
    // period after the done cycle.
    system_0_sysid_period_timer #(
        .RECHECK_CYCLES(RECHECK_CYCLES)
    ) u_period_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .reload  (done_pending),
        .expire  (period_expire)
    );

    assign trigger = start | period_expire;
`else
    assign trigger = start;
`endif

    assign lat_last = (lat_cnt == LAT_MAX);
    assign id_match = word_match(id_raw, EXPECTED_ID);
    assign ts_match = word_match(ts_raw, EXPECTED_TS);

    always_comb begin
        state_next    = state;
        sysid_read    = 1'b0;
        sysid_address = SYSID_ADDR_ID;
        busy          = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (trigger) state_next = RD_ID;
            end
            RD_ID: begin
                sysid_read = 1'b1;
                if (lat_last) state_next = RD_TS;
            end
            RD_TS: begin
                sysid_read    = 1'b1;
                sysid_address = SYSID_ADDR_TS;
                if (lat_last) state_next = CMP;
            end
            CMP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read phase: hold each address for READ_LATENCY+1 cycles, sample in the last.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            lat_cnt <= '0;
            id_raw  <= '0;
            ts_raw  <= '0;
        end else begin
            state <= state_next;
            if (sysid_read && !lat_last) begin
                lat_cnt <= lat_cnt + 2'd1;
            end else begin
                lat_cnt <= '0;
            end
            if (state == RD_ID && lat_last) id_raw <= sysid_readdata;
            if (state == RD_TS && lat_last) ts_raw <= sysid_readdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            captured_id  <= '0;
            captured_ts  <= '0;
            id_ok        <= 1'b0;
            ts_ok        <= 1'b0;
            fail_sticky  <= 1'b0;
            done_pending <= 1'b0;
            done         <= 1'b0;
        end else begin
            done_pending <= (state == CMP);
            done         <= done_pending;
            if (state == CMP) begin
                captured_id <= id_raw;
                captured_ts <= ts_raw;
                id_ok       <= id_match;
                ts_ok       <= ts_match;
            end
            if (state == CMP && !(id_match && ts_match)) begin
                fail_sticky <= 1'b1;
            end else if (clear_sticky) begin
                fail_sticky <= 1'b0;
            end
        end
    end

endmodule
